// File: rtl/eth_rmii_phy_gen.sv
// rtl/eth_rmii_phy_gen.sv - RMII PHY-side frame generator (preamble, payload, FCS, IPG)
//
// Ports:
//   clk_mac   - 50 MHz RMII reference clock
//   rst_n     - asynchronous active-low reset
//   tx_vld/tx_dat/tx_sof/tx_eof/tx_err - byte source; held stable until tx_ack
//   tx_ack    - one-cycle pulse, presented byte consumed at the end of this cycle
//   eth_crsdv/eth_rxd/eth_rxerr - PHY-side RMII receive pins
//   busy      - high outside IDLE
//   frm_done  - pulse on normal frame completion
//   frm_abort - pulse on underrun / overlength abort
module eth_rmii_phy_gen #(
    parameter bit FCS_EN     = 1'b1,
    parameter int IPG_CYCLES = 48,
    parameter int MAX_LEN    = 1514
) (
    input  logic       clk_mac,
    input  logic       rst_n,
    input  logic       tx_vld,
    input  logic [7:0] tx_dat,
    input  logic       tx_sof,
    input  logic       tx_eof,
    input  logic       tx_err,
    output logic       tx_ack,
    output logic       eth_crsdv,
    output logic [1:0] eth_rxd,
    output logic       eth_rxerr,
    output logic       busy,
    output logic       frm_done,
    output logic       frm_abort
);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_FCS, S_ABORT, S_IPG} state_t;

    localparam logic [15:0] IPG_LAST = 16'(IPG_CYCLES - 1);
    localparam logic [10:0] MAX_B    = 11'(MAX_LEN);

    state_t      state_q, state_n;
    logic [15:0] cnt_q, cnt_n;
    logic [10:0] byte_cnt_q, byte_cnt_n;
    logic [31:0] sr_q, sr_n;
    logic [31:0] crc_q, crc_n;
    logic        err_q, err_n;
    logic        eof_q, eof_n;
    logic        ack_n, crsdv_n, rxerr_n, busy_n, done_n, abort_n;
    logic [1:0]  rxd_n;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    // state_q/cnt_q describe what is on the pins in the current cycle; the
    // output flops are loaded from the next-state values so they stay aligned.
    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q + 16'd1;
        byte_cnt_n = byte_cnt_q;
        sr_n       = {2'b00, sr_q[31:2]};
        crc_n      = crc_q;
        err_n      = err_q;
        eof_n      = eof_q;
        ack_n      = 1'b0;
        done_n     = 1'b0;
        abort_n    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_n = 16'd0;
                // tx_ack high means the presented byte is consumed at this edge
                if (tx_vld && !tx_ack) begin
                    if (tx_sof) begin
                        state_n    = S_PRE;
                        crc_n      = 32'hFFFF_FFFF;
                        byte_cnt_n = 11'd0;
                    end else begin
                        ack_n = 1'b1;
                    end
                end
            end
            S_PRE, S_DATA: begin
                if ((state_q == S_PRE && cnt_q == 16'd31) ||
                    (state_q == S_DATA && cnt_q == 16'd3)) begin
                    if (state_q == S_DATA && eof_q) begin
                        cnt_n = 16'd0;
                        if (FCS_EN) begin
                            state_n = S_FCS;
                            sr_n    = ~crc_q;
                        end else begin
                            state_n = S_IPG;
                            done_n  = 1'b1;
                        end
                    end else if (tx_ack) begin
                        state_n    = S_DATA;
                        cnt_n      = 16'd0;
                        sr_n       = {24'h0, tx_dat};
                        err_n      = tx_err;
                        eof_n      = tx_eof;
                        crc_n      = crc_byte(crc_q, tx_dat);
                        byte_cnt_n = byte_cnt_q + 11'd1;
                    end else begin
                        // no ack at the slot: underrun or overlength
                        state_n = S_ABORT;
                        cnt_n   = 16'd0;
                    end
                end
            end
            S_FCS: begin
                if (cnt_q == 16'd15) begin
                    state_n = S_IPG;
                    cnt_n   = 16'd0;
                    done_n  = 1'b1;
                end
            end
            S_ABORT: begin
                if (cnt_q == 16'd3) begin
                    state_n = S_IPG;
                    cnt_n   = 16'd0;
                    abort_n = 1'b1;
                end
            end
            S_IPG: begin
                if (cnt_q == IPG_LAST) begin
                    state_n = S_IDLE;
                    cnt_n   = 16'd0;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Ack is raised for the cycle that drives the last dibit before a new byte
        // is needed; the byte itself is latched at the end of that cycle.
        if (tx_vld && ((state_n == S_PRE && cnt_n == 16'd31) ||
                       (state_n == S_DATA && cnt_n == 16'd3 && !eof_n && byte_cnt_n != MAX_B))) begin
            ack_n = 1'b1;
        end

        crsdv_n = (state_n == S_PRE) || (state_n == S_DATA) ||
                  (state_n == S_FCS) || (state_n == S_ABORT);
        case (state_n)
            S_PRE:         rxd_n = (cnt_n == 16'd31) ? 2'b11 : 2'b01;
            S_DATA, S_FCS: rxd_n = sr_n[1:0];
            default:       rxd_n = 2'b00;
        endcase
        rxerr_n = (state_n == S_ABORT) || (state_n == S_DATA && err_n);
        busy_n  = (state_n != S_IDLE);
    end

    always_ff @(posedge clk_mac or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 16'd0;
            byte_cnt_q <= 11'd0;
            sr_q       <= 32'd0;
            crc_q      <= 32'd0;
            err_q      <= 1'b0;
            eof_q      <= 1'b0;
            tx_ack     <= 1'b0;
            eth_crsdv  <= 1'b0;
            eth_rxd    <= 2'b00;
            eth_rxerr  <= 1'b0;
            busy       <= 1'b0;
            frm_done   <= 1'b0;
            frm_abort  <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            byte_cnt_q <= byte_cnt_n;
            sr_q       <= sr_n;
            crc_q      <= crc_n;
            err_q      <= err_n;
            eof_q      <= eof_n;
            tx_ack     <= ack_n;
            eth_crsdv  <= crsdv_n;
            eth_rxd    <= rxd_n;
            eth_rxerr  <= rxerr_n;
            busy       <= busy_n;
            frm_done   <= done_n;
            frm_abort  <= abort_n;
        end
    end

endmodule

// File: doc/eth_rmii_phy_gen.md
ETH_RMII_PHY_GEN -- requirements
Module: eth_rmii_phy_gen

Interface
REQ-001 Parameter FCS_EN, default 1, 1 = append IEEE 802.3 FCS after payload, 0 = payload only.
REQ-002 Parameter IPG_CYCLES, default 48, idle clocks enforced after every frame.
REQ-003 Parameter MAX_LEN, default 1514, maximum payload bytes per frame excluding FCS.
REQ-004 clk_mac  in  1  50 MHz RMII reference clock, sole clock; all logic on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 tx_vld  in  1  tx_dat holds a byte to send.
REQ-007 tx_dat  in  8  payload byte.
REQ-008 tx_sof  in  1  byte is the first of a frame.
REQ-009 tx_eof  in  1  byte is the last of a frame.
REQ-010 tx_err  in  1  assert eth_rxerr while this byte is serialized.
REQ-011 tx_ack  out  1  one-cycle pulse: presented byte consumed.
REQ-012 eth_crsdv  out  1  PHY-side RMII CRS_DV.
REQ-013 eth_rxd  out  2  PHY-side RMII RXD, dibit {b1,b0}, LSB dibit first.
REQ-014 eth_rxerr  out  1  PHY-side RMII RX_ER.
REQ-015 busy  out  1  high in any state except IDLE.
REQ-016 frm_done  out  1  one-cycle pulse on normal frame completion.
REQ-017 frm_abort  out  1  one-cycle pulse on underrun or overlength abort.

Function
REQ-018 States SHALL be IDLE, PRE, DATA, FCS, ABORT, IPG; all outputs registered.
REQ-019 IDLE: eth_crsdv=0, eth_rxd=00, eth_rxerr=0; tx_vld&tx_sof -> PRE next cycle, that byte not acked yet.
REQ-020 IDLE with tx_vld&!tx_sof SHALL pulse tx_ack and discard the byte (no line activity).
REQ-021 PRE: eth_crsdv=1 for 32 cycles: 28 dibits 01 (7x0x55) then SFD 0xD5 as 01,01,01,11.
REQ-022 A byte is accepted (tx_ack=1, latched) on the cycle the last dibit of SFD or of the previous payload byte is driven, if tx_vld=1; its first dibit appears the next cycle.
REQ-023 DATA: each byte occupies exactly 4 cycles, dibits bits[1:0],[3:2],[5:4],[7:6]; no gaps between bytes.
REQ-024 tx_err on an accepted byte SHALL hold eth_rxerr=1 for exactly its 4 cycles.
REQ-025 tx_vld=0 at an acceptance cycle (underrun) -> ABORT: eth_crsdv=1, eth_rxerr=1, eth_rxd=00 for 4 cycles, then frm_abort pulse, then IPG.
REQ-026 tx_sof on a byte accepted in DATA SHALL be ignored (byte treated as payload).
REQ-027 11-bit payload counter; byte number MAX_LEN+1 without tx_eof SHALL not be acked and SHALL enter ABORT.
REQ-028 After the tx_eof byte: FCS_EN=1 -> FCS, 16 cycles; FCS_EN=0 -> IPG directly.
REQ-029 CRC: reflected poly 0xEDB88320, init 0xFFFFFFFF, over payload only; FCS = bitwise inverse, sent LSB byte first, LSB dibit first.
REQ-030 frm_done SHALL pulse on the cycle after the last payload/FCS dibit, coincident with eth_crsdv falling to 0.
REQ-031 IPG: eth_crsdv=0, eth_rxd=00 for IPG_CYCLES cycles; tx_vld ignored, no tx_ack; then IDLE.
REQ-032 tx_ack SHALL never be high outside REQ-020/REQ-022 cases.

Reset
REQ-033 rst_n low SHALL immediately force state IDLE, all counters/CRC cleared, tx_ack=busy=frm_done=frm_abort=0, eth_crsdv=0, eth_rxd=00, eth_rxerr=0, regardless of frame progress.
REQ-034 After rst_n release, first frame SHALL start without IPG.

Verification
REQ-035 Single byte 0x00 with sof+eof, FCS_EN=1 -> 32 preamble/SFD dibits, 00x4, FCS bytes 8D EF 02 D2; eth_crsdv high 52 cycles; frm_done once; then 48 idle cycles.
REQ-036 64-byte frame, tx_vld continuous -> tx_ack every 4 cycles, 64 acks, eth_crsdv high 32+256+16 cycles, FCS matches software CRC32.
REQ-037 Drop tx_vld at byte 10 -> 10 acks, eth_rxerr high 4 cycles, frm_abort once, no FCS, frm_done never.
REQ-038 tx_err on byte 3 of 5 -> eth_rxerr high only cycles of byte 3, FCS unaffected.
REQ-039 1515 bytes, no eof -> 1514 acks, ABORT; exactly 1514 bytes, eof on last -> normal FCS.
REQ-040 rst_n low mid-DATA -> outputs zero same cycle; loopback into eth_rx after reset: frame received with rx_err=0, data matching.
